// File: rtl/serializer_fifo_pkg.sv
// Shared types for serializer_fifo: FIFO entry, shifter state and the length decode.
package serializer_pkg;
    localparam int unsigned SER_WIDTH = 16;
    localparam int unsigned SER_LEN_W = $clog2(SER_WIDTH) + 1;

    typedef struct packed {
        logic [SER_WIDTH-1:0] data;
        logic [SER_LEN_W-1:0] len;
    } ser_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // Modes 1 and 2 are discard codes (length 0); mode 0 selects the full word.
    function automatic int unsigned ser_len(input int unsigned mod, input int unsigned width);
        if (mod == 0) return width;
        if (mod < 3) return 0;
        return mod;
    endfunction
endpackage

// File: rtl/serializer_fifo_fifo.sv
// Synchronous FIFO of serializer entries with occupancy count.
module ser_fifo
    import serializer_pkg::*;
#(
    parameter type         entry_t = ser_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     push_i,
    input  entry_t                   wdata_i,
    input  logic                     pop_i,
    output entry_t                   rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
endmodule

// File: rtl/serializer_fifo.sv
// Parallel-to-serial converter with input FIFO and per-word bit length.
// Optional SERIALIZER_FIFO_BYPASS_EN loads an idle shifter straight from the input.
module serializer_fifo
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 4,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic [$clog2(WIDTH)-1:0]   data_mod_i,
    input  logic                       data_val_i,
    output logic                       data_rdy_o,
    output logic                       ser_data_o,
    output logic                       ser_data_val_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int unsigned LW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LW-1:0]    len;
    } entry_t;

    ser_state_e        state_q, state_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              rdy_q;
    logic              full_c, empty_c;
    logic              accept_c, keep_c, push_c, pop_c, bypass_c;
    logic [LW-1:0]     len_c;
    entry_t            in_entry_c, head_c;
    logic [AW:0]       level_c;

    assign data_rdy_o = rdy_q && !full_c;
    assign accept_c   = data_val_i && data_rdy_o;
    assign len_c      = LW'(ser_len(32'(data_mod_i), WIDTH));
    assign keep_c     = accept_c && (len_c != '0);
    assign push_c     = keep_c && !bypass_c;
    assign in_entry_c = '{data: data_i, len: len_c};

    ser_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .push_i  (push_c),
        .wdata_i (in_entry_c),
        .pop_i   (pop_c),
        .rdata_o (head_c),
        .full_o  (full_c),
        .empty_o (empty_c),
        .level_o (level_c)
    );

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
        end
    end

    // On the last bit a queued word is popped so the stream continues without a gap.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        pop_c    = 1'b0;
        bypass_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    state_d = ST_SHIFT;
                    sreg_d  = head_c.data;
                    cnt_d   = head_c.len;
                end
`ifdef SERIALIZER_FIFO_BYPASS_EN
                else if (keep_c) begin
                    bypass_c = 1'b1;
                    state_d  = ST_SHIFT;
                    sreg_d   = data_i;
                    cnt_d    = len_c;
                end
`endif
            end
            ST_SHIFT: begin
                if (cnt_q == LW'(1)) begin
                    if (!empty_c) begin
                        pop_c  = 1'b1;
                        sreg_d = head_c.data;
                        cnt_d  = head_c.len;
                    end else begin
                        state_d = ST_IDLE;
                        sreg_d  = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
                    cnt_d  = cnt_q - LW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ser_data_val_o = (state_q == ST_SHIFT);
    assign ser_data_o     = ser_data_val_o && (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]);
    assign busy_o         = ser_data_val_o || (level_c != '0);
    assign level_o        = level_c;
endmodule

// File: tb/tb_serializer_fifo.sv
// Self-checking bench for serializer_fifo: MSB-first and LSB-first instances share stimulus.
module tb_serializer_fifo;
    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned MW = 4;
    localparam int unsigned LV = 3;
`ifdef SERIALIZER_FIFO_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          srst_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic [MW-1:0] mod_i = '0;
    logic          val_i = 1'b0;
    logic          rdy_m, ser_m, sval_m, busy_m;
    logic          rdy_l, ser_l, sval_l, busy_l;
    logic [LV-1:0] lvl_m, lvl_l;

    always #5 clk = ~clk;

    serializer_fifo #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(1'b0)) dut_m (
        .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_mod_i(mod_i), .data_val_i(val_i),
        .data_rdy_o(rdy_m), .ser_data_o(ser_m), .ser_data_val_o(sval_m), .busy_o(busy_m), .level_o(lvl_m));

    serializer_fifo #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(1'b1)) dut_l (
        .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_mod_i(mod_i), .data_val_i(val_i),
        .data_rdy_o(rdy_l), .ser_data_o(ser_l), .ser_data_val_o(sval_l), .busy_o(busy_l), .level_o(lvl_l));

    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    int vcount = 0;
    bit qm[$];
    bit ql[$];
    int unsigned mlen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_len(input int unsigned mod);
        if (mod == 0) return W;
        if (mod <= 2) return 0;
        return mod;
    endfunction

    // Reference: each accepted word becomes its list of expected bits in both orders.
    always @(posedge clk) begin
        if (!srst_i) begin
            qm.delete();
            ql.delete();
        end else if (val_i && rdy_m) begin
            mlen = model_len(32'(mod_i));
            for (int i = 0; i < int'(mlen); i++) begin
                qm.push_back(data_i[W-1-i]);
                ql.push_back(data_i[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_m", 32'(busy_m), 32'(qm.size() != 0));
            check("busy_l", 32'(busy_l), 32'(ql.size() != 0));
            if (sval_m) begin
                vcount++;
                if (qm.size() == 0) check("extra_bit_m", 32'(1), 32'(0));
                else check("bit_m", 32'(ser_m), 32'(qm.pop_front()));
            end else check("idle_data_m", 32'(ser_m), 32'(0));
            if (sval_l) begin
                if (ql.size() == 0) check("extra_bit_l", 32'(1), 32'(0));
                else check("bit_l", 32'(ser_l), 32'(ql.pop_front()));
            end else check("idle_data_l", 32'(ser_l), 32'(0));
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [MW-1:0] m);
        int t = 0;
        while (!rdy_m && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rdy_m) begin
            check("send_timeout", 32'(0), 32'(1));
            return;
        end
        data_i = d;
        mod_i  = m;
        val_i  = 1'b1;
        @(negedge clk);
        val_i  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy_m || busy_l) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(busy_m || busy_l), 32'(0));
    endtask

    typedef struct {
        logic [W-1:0]  data;
        logic [MW-1:0] mod;
        int            len;
        logic [W-1:0]  msb;
        logic [W-1:0]  lsb;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [W-1:0] cm, cl;
        int cnt, first, last, lvl_max;
        bit busy_any;
        int v0, t;

        vt[0] = '{16'hA5C3, 4'd0,  16, 16'hA5C3, 16'hC3A5};
        vt[1] = '{16'hFFFF, 4'd1,  0,  16'h0000, 16'h0000};
        vt[2] = '{16'hFFFF, 4'd2,  0,  16'h0000, 16'h0000};
        vt[3] = '{16'h000B, 4'd4,  4,  16'h0000, 16'h000D};
        vt[4] = '{16'h8001, 4'd3,  3,  16'h0004, 16'h0004};
        vt[5] = '{16'h1234, 4'd15, 15, 16'h091A, 16'h1624};
        vt[6] = '{16'hFFFF, 4'd0,  16, 16'hFFFF, 16'hFFFF};

        // Reset held for two edges.
        @(negedge clk);
        @(negedge clk);
        check("rst_rdy",   32'(rdy_m || rdy_l), 32'(0));
        check("rst_val",   32'(sval_m || sval_l), 32'(0));
        check("rst_data",  32'(ser_m || ser_l), 32'(0));
        check("rst_busy",  32'(busy_m || busy_l), 32'(0));
        check("rst_level", 32'({lvl_m, lvl_l}), 32'(0));
        srst_i = 1'b1;
        @(negedge clk);
        check("rel_rdy_m", 32'(rdy_m), 32'(1));
        check("rel_rdy_l", 32'(rdy_l), 32'(1));
        mon_en = 1'b1;

        // Single-word vectors.
        for (int v = 0; v < 7; v++) begin
            wait_idle("pre_vec_idle");
            send(vt[v].data, vt[v].mod);
            cm = '0; cl = '0; cnt = 0; first = 0; last = 0; lvl_max = 0; busy_any = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                if (sval_m) begin
                    cm = {cm[W-2:0], ser_m};
                    cl = {cl[W-2:0], ser_l};
                    cnt++;
                    if (first == 0) first = k;
                    last = k;
                end
                if (int'(lvl_m) > lvl_max) lvl_max = int'(lvl_m);
                if (busy_m) busy_any = 1'b1;
                @(negedge clk);
            end
            check($sformatf("vec%0d_len", v), 32'(cnt), 32'(vt[v].len));
            check($sformatf("vec%0d_msb", v), 32'(cm), 32'(vt[v].msb));
            check($sformatf("vec%0d_lsb", v), 32'(cl), 32'(vt[v].lsb));
            if (vt[v].len > 0) begin
                check($sformatf("vec%0d_latency", v), 32'(first), 32'(EXP_LAT));
                check($sformatf("vec%0d_contig", v), 32'(last - first + 1), 32'(vt[v].len));
            end else begin
                check($sformatf("vec%0d_disc_level", v), 32'(lvl_max), 32'(0));
                check($sformatf("vec%0d_disc_busy", v), 32'(busy_any), 32'(0));
            end
            check($sformatf("vec%0d_end_val", v), 32'(sval_m || sval_l), 32'(0));
        end

        // Fill: five full words back to back into a depth-4 FIFO.
        wait_idle("pre_fill_idle");
        v0 = vcount;
        for (int w = 0; w < 5; w++) send(W'($urandom), 4'd0);
        check("fill_level", 32'(lvl_m), 32'(4));
        check("fill_rdy",   32'(rdy_m), 32'(0));
        cnt = 0;
        for (int k = 0; k < 200 && (busy_m || busy_l); k++) begin
            if (sval_m && (vcount - v0) < 80) begin end
            else if (!sval_m && busy_m && (vcount - v0) > 0) cnt++;
            @(negedge clk);
        end
        check("fill_gaps", 32'(cnt), 32'(0));
        check("fill_bits", 32'(vcount - v0), 32'(80));
        wait_idle("fill_idle");

        // Reset with one word shifting and two queued.
        v0 = vcount;
        for (int w = 0; w < 3; w++) send(W'($urandom), 4'd0);
        check("mid_level", 32'(lvl_m), 32'(2));
        t = 0;
        while ((vcount - v0) < 8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mid_reach_bit7", 32'((vcount - v0) >= 8), 32'(1));
        srst_i = 1'b0;
        @(negedge clk);
        check("mid_val",   32'(sval_m || sval_l), 32'(0));
        check("mid_lvl",   32'({lvl_m, lvl_l}), 32'(0));
        check("mid_busy",  32'(busy_m || busy_l), 32'(0));
        check("mid_rdy",   32'(rdy_m || rdy_l), 32'(0));
        srst_i = 1'b1;
        @(negedge clk);
        check("mid_rel_rdy", 32'(rdy_m && rdy_l), 32'(1));
        v0 = vcount;
        repeat (30) @(negedge clk);
        check("mid_no_stale", 32'(vcount - v0), 32'(0));

        // Randomised traffic against the bit-queue model.
        for (int i = 0; i < 3000; i++) begin
            val_i  = ($urandom_range(0, 3) != 0);
            data_i = W'($urandom);
            mod_i  = ($urandom_range(0, 3) == 0) ? 4'd0 : MW'($urandom);
            @(negedge clk);
        end
        val_i = 1'b0;
        wait_idle("rand_drain");
        check("rand_q_m_empty", 32'(qm.size()), 32'(0));
        check("rand_q_l_empty", 32'(ql.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serializer_fifo.md
# serializer_fifo

Parametrised successor to the team's single-word serializer. Accepts parallel words with a per-word valid-bit count into a small input FIFO, so upstream can push while a word is still shifting out, and streams the bits one per clock with selectable bit order. It sits between a parallel producer and any one-bit serial consumer. Back-to-back words are emitted with no idle cycles.

## Interface
- `WIDTH`, 16: parallel word width; ≥ 4.
- `DEPTH`, 4: FIFO depth in words; power of two, ≥ 2.
- `LSB_FIRST`, 0: 0 = MSB first; 1 = LSB first.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `srst_i`  in  1  synchronous reset, active-low.
- `data_i`  in  WIDTH  parallel word.
- `data_mod_i`  in  $clog2(WIDTH)  valid-bit count.
- `data_val_i`  in  1  word valid.
- `data_rdy_o`  out  1  FIFO can accept a word.
- `ser_data_o`  out  1  serial bit.
- `ser_data_val_o`  out  1  `ser_data_o` valid.
- `busy_o`  out  1  high while shifting or while the FIFO is non-empty.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Handshake: a word is accepted on an edge where `data_val_i && data_rdy_o`. `data_rdy_o = !full`.
- Length decode happens at accept:
  - `data_mod_i == 0` → WIDTH bits.
  - `data_mod_i == 1` or `2` → word is accepted but discarded; nothing is stored and nothing is output.
  - Otherwise → `data_mod_i` bits.
- Bit selection:
  - MSB first: bits `data_i[WIDTH-1]` down to `data_i[WIDTH-len]`.
  - LSB first: bits `data_i[0]` up to `data_i[len-1]`.
- Shifter states:
  - IDLE → SHIFT when a word is popped.
  - SHIFT stays while the remaining count is > 1.
  - On the last bit: if the FIFO is non-empty, pop and stay in SHIFT; otherwise go to IDLE.
- `ser_data_o` is 0 whenever `ser_data_val_o` is 0.
- `busy_o` = (state == SHIFT) || (level ≠ 0).
- Push and pop on the same edge are allowed at any occupancy below full. When full, no push occurs, because `data_rdy_o` is low.
- `data_i` and `data_mod_i` are sampled only at accept. Later changes have no effect.

## Timing
- Reset (`srst_i` low at an edge): all outputs 0, FIFO emptied, state IDLE, in-flight word dropped.
- `data_rdy_o` is 0 while `srst_i` is low and 1 on the first cycle after release.
- Latency, base build: word accepted at edge E, popped at E+1, first bit valid in the cycle after E+1.
- Back-to-back words: the last bit of word n is followed directly by the first bit of word n+1 in the next cycle. `ser_data_val_o` stays high throughout.
- `ser_data_val_o` falls in the cycle after the last bit when the FIFO is empty. `busy_o` falls in the same cycle.
- `level_o` updates at the accept or pop edge. It is unchanged on a simultaneous push and pop.

## Configuration
- `SERIALIZER_FIFO_BYPASS_EN` defined:
  - Applies when the shifter is IDLE and the FIFO is empty.
  - The accepted word loads the shifter directly at edge E.
  - The first bit is valid in the cycle after E, saving one cycle.
  - `level_o` stays 0.
- Not defined: every word passes through the FIFO, with the latency given under Timing.
- Bit stream content and order are identical in both builds.

## Structure
- `serializer_pkg` holds:
  - `ser_entry_t` struct {`data` [WIDTH-1:0], `len` [$clog2(WIDTH):0]}, parametrised via a class or a localparam default of 16.
  - Function `ser_len(mod)` implementing the length decode, returning 0 for discard.
- Sub-module `ser_fifo`: synchronous FIFO of `ser_entry_t`, DEPTH entries. Ports: push, pop, full, empty, level.
- Top module: handshake, length decode, shift register, bit counter, state register.

## Test plan
- Reset: hold `srst_i` low for 2 cycles → all outputs 0; after release `data_rdy_o` = 1.
- MSB first, `16'hA5C3`, mod 0 → 16 valid bits `1010010111000011`, then valid and busy fall. Latency is 2 cycles in the base build and 1 with bypass.
- Discard: `16'hFFFF` with mod 1, then mod 2 → `ser_data_val_o` never rises, `level_o` stays 0, `busy_o` stays 0.
- `LSB_FIRST`=1, `16'h000B`, mod 4 → bits `1,1,0,1`, exactly 4 valid cycles.
- Fill: push 5 words of mod 0 with no gaps (DEPTH 4) → `data_rdy_o` drops at `level_o` 4. The stream is continuous with no valid gap across word boundaries, and no word is lost.
- Reset mid-word: assert `srst_i` at bit 7 of 16 with 2 words queued → the next cycle has valid 0, `level_o` 0, `busy_o` 0, and no stale bits after release.
